// File: rtl/product_acc_pkg.sv
// Shared constants, FSM states and the S1->S2 pipeline record for the
// sparse-conv product accumulator.
package product_acc_pkg;

    localparam int DEF_ACC_WIDTH    = 24;
    localparam int COORD_WIDTH      = 16;
    localparam int COUNT_WIDTH      = 9;
    localparam int DIM_WIDTH        = 9;
    localparam int PLANE_ADDR_WIDTH = 18;
    localparam int DROP_WIDTH       = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FLUSH,
        ST_CLEAR
    } state_e;

    typedef struct packed {
        logic                        valid;
        logic [PLANE_ADDR_WIDTH-1:0] addr;
        logic [COORD_WIDTH-1:0]      product;
    } pipe_t;

    // Signed coordinates are compared unsigned once the sign bit is known clear.
    function automatic logic in_plane(input logic [COORD_WIDTH-1:0] row,
                                      input logic [COORD_WIDTH-1:0] col,
                                      input logic [DIM_WIDTH-1:0]   dim);
        return !row[COORD_WIDTH-1] && !col[COORD_WIDTH-1]
            && (row < COORD_WIDTH'(dim)) && (col < COORD_WIDTH'(dim));
    endfunction

endpackage

// File: rtl/product_acc_ram.sv
// Output buffer: one synchronous read port, one write port; a read that
// collides with a write to the same address returns the old contents.
module product_acc_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/product_accumulator.sv
// Batch product accumulator with 2-stage RMW pipeline and forwarding.
// Define PRODUCT_ACC_SATURATE_EN to clamp sums instead of wrapping.
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int MAX_OUTPUTS = 256,
    parameter int ACC_DEPTH   = 1024,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   batch_valid,
    output logic                                   batch_ready,
    input  logic [COUNT_WIDTH-1:0]                 batch_count,
    input  logic [MAX_OUTPUTS-1:0][COORD_WIDTH-1:0] products,
    input  logic [MAX_OUTPUTS-1:0][COORD_WIDTH-1:0] row_coordinate,
    input  logic [MAX_OUTPUTS-1:0][COORD_WIDTH-1:0] column_coordinate,
    input  logic [DIM_WIDTH-1:0]                   output_dim,
    input  logic                                   clear,
    input  logic                                   rd_en,
    input  logic [$clog2(ACC_DEPTH)-1:0]           rd_addr,
    output logic signed [ACC_WIDTH-1:0]            rd_data,
    output logic                                   busy,
    output logic [DROP_WIDTH-1:0]                  dropped_count
);

    localparam int AW = $clog2(ACC_DEPTH);
    localparam int IW = (MAX_OUTPUTS > 1) ? $clog2(MAX_OUTPUTS) : 1;
    localparam logic [31:0] DEPTH_U = 32'(ACC_DEPTH);

    state_e state, state_d;

    logic [MAX_OUTPUTS-1:0][COORD_WIDTH-1:0] prod_q, row_q, col_q;
    logic [COUNT_WIDTH-1:0]      count_q;
    logic [DIM_WIDTH-1:0]        dim_q;
    logic [IW-1:0]               idx;
    logic [AW-1:0]               clr_addr;
    logic                        accept, start_clear, last_entry, last_clear;

    logic [COORD_WIDTH-1:0]      row_k, col_k;
    logic [PLANE_ADDR_WIDTH-1:0] s1_addr;
    logic                        s1_hit, s1_keep, s1_drop;

    pipe_t                       s2;
    logic                        fwd_vld;
    logic [PLANE_ADDR_WIDTH-1:0] fwd_addr;
    logic [ACC_WIDTH-1:0]        fwd_data;
    logic [ACC_WIDTH-1:0]        s2_old, s2_sum;
    logic [ACC_WIDTH:0]          sum_wide;

    logic                        ram_re, ram_we;
    logic [AW-1:0]               ram_raddr, ram_waddr;
    logic [ACC_WIDTH-1:0]        ram_rdata, ram_wdata;
    logic                        drain_q;
    logic [ACC_WIDTH-1:0]        rd_hold;

    assign batch_ready = (state == ST_IDLE) && !clear;
    assign busy        = (state != ST_IDLE);
    assign accept      = batch_valid && batch_ready;
    assign start_clear = (state == ST_IDLE) && clear;
    assign last_entry  = (idx == IW'(count_q - 1'b1));
    assign last_clear  = (clr_addr == AW'(ACC_DEPTH - 1));

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (start_clear)                       state_d = ST_CLEAR;
                else if (accept && (batch_count != '0)) state_d = ST_SCAN;
            end
            ST_SCAN:  if (last_entry) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_IDLE;
            ST_CLEAR: if (last_clear) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            clr_addr <= '0;
        end else begin
            state <= state_d;
            if (accept)                idx <= '0;
            else if (state == ST_SCAN) idx <= idx + 1'b1;
            if (start_clear)            clr_addr <= '0;
            else if (state == ST_CLEAR) clr_addr <= clr_addr + 1'b1;
        end
    end

    // Batch payload is plain data; only the control path needs reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            prod_q  <= products;
            row_q   <= row_coordinate;
            col_q   <= column_coordinate;
            count_q <= batch_count;
            dim_q   <= output_dim;
        end
    end

    // S1: range check and plane address of the entry being walked.
    always_comb begin
        row_k   = row_q[idx];
        col_k   = col_q[idx];
        s1_addr = PLANE_ADDR_WIDTH'(row_k[DIM_WIDTH-1:0]) * PLANE_ADDR_WIDTH'(dim_q)
                + PLANE_ADDR_WIDTH'(col_k[DIM_WIDTH-1:0]);
        s1_hit  = in_plane(row_k, col_k, dim_q) && (32'(s1_addr) < DEPTH_U);
        s1_keep = (state == ST_SCAN) && s1_hit;
        s1_drop = (state == ST_SCAN) && !s1_hit;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2            <= '0;
            fwd_vld       <= 1'b0;
            fwd_addr      <= '0;
            fwd_data      <= '0;
            dropped_count <= '0;
        end else begin
            s2.valid   <= s1_keep;
            s2.addr    <= s1_addr;
            s2.product <= prod_q[idx];
            fwd_vld    <= s2.valid;
            fwd_addr   <= s2.addr;
            fwd_data   <= s2_sum;
            if (start_clear)
                dropped_count <= '0;
            else if (s1_drop && (dropped_count != '1))
                dropped_count <= dropped_count + 1'b1;
        end
    end

    // S2: the write one cycle back lands on the same edge as our read, so
    // the RAM returns stale data for it; take the registered sum instead.
    always_comb begin
        s2_old   = (fwd_vld && (fwd_addr == s2.addr)) ? fwd_data : ram_rdata;
        sum_wide = {s2_old[ACC_WIDTH-1], s2_old}
                 + {{(ACC_WIDTH+1-COORD_WIDTH){s2.product[COORD_WIDTH-1]}}, s2.product};
`ifdef PRODUCT_ACC_SATURATE_EN
        if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1])
            s2_sum = sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        else
            s2_sum = sum_wide[ACC_WIDTH-1:0];
`else
        s2_sum = sum_wide[ACC_WIDTH-1:0];
`endif
    end

    assign ram_re    = (state == ST_IDLE) ? rd_en : s1_keep;
    assign ram_raddr = (state == ST_IDLE) ? rd_addr : s1_addr[AW-1:0];
    assign ram_we    = (state == ST_CLEAR) || s2.valid;
    assign ram_waddr = (state == ST_CLEAR) ? clr_addr : s2.addr[AW-1:0];
    assign ram_wdata = (state == ST_CLEAR) ? '0 : s2_sum;

    product_acc_ram #(
        .DEPTH (ACC_DEPTH),
        .WIDTH (ACC_WIDTH)
    ) u_ram (
        .clk   (clk),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata)
    );

    // Pipeline reads share the RAM output, so drain data is captured and held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drain_q <= 1'b0;
            rd_hold <= '0;
        end else begin
            drain_q <= (state == ST_IDLE) && rd_en;
            if (drain_q) rd_hold <= ram_rdata;
        end
    end

    assign rd_data = drain_q ? ram_rdata : rd_hold;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator against a sequential
// accumulate-per-entry model of the output plane.
module tb_product_accumulator;

    localparam int MAXO  = 256;
    localparam int DEPTH = 1024;
    localparam int W     = 16;
    localparam int AWT   = 10;
`ifdef PRODUCT_ACC_SATURATE_EN
    localparam int SAT_EXP = 32767;
`else
    localparam int SAT_EXP = -200;
`endif

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   batch_valid = 1'b0;
    logic                   batch_ready;
    logic [8:0]             batch_count = '0;
    logic [MAXO-1:0][15:0]  products = '0;
    logic [MAXO-1:0][15:0]  row_coordinate = '0;
    logic [MAXO-1:0][15:0]  column_coordinate = '0;
    logic [8:0]             output_dim = '0;
    logic                   clear = 1'b0;
    logic                   rd_en = 1'b0;
    logic [AWT-1:0]         rd_addr = '0;
    logic signed [W-1:0]    rd_data;
    logic                   busy;
    logic [15:0]            dropped_count;

    int checks = 0;
    int failures = 0;
    int model_mem [DEPTH];
    int model_drop = 0;
    int e_prod [MAXO];
    int e_row  [MAXO];
    int e_col  [MAXO];

    product_accumulator #(
        .MAX_OUTPUTS (MAXO),
        .ACC_DEPTH   (DEPTH),
        .ACC_WIDTH   (W)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .batch_valid       (batch_valid),
        .batch_ready       (batch_ready),
        .batch_count       (batch_count),
        .products          (products),
        .row_coordinate    (row_coordinate),
        .column_coordinate (column_coordinate),
        .output_dim        (output_dim),
        .clear             (clear),
        .rd_en             (rd_en),
        .rd_addr           (rd_addr),
        .rd_data           (rd_data),
        .busy              (busy),
        .dropped_count     (dropped_count)
    );

    always #5 clk = ~clk;

    function automatic int acc_step(input int old, input int p);
        int s;
        s = old + p;
`ifdef PRODUCT_ACC_SATURATE_EN
        if (s > (1 << (W-1)) - 1) s = (1 << (W-1)) - 1;
        if (s < -(1 << (W-1)))    s = -(1 << (W-1));
        return s;
`else
        return int'($signed(s[W-1:0]));
`endif
    endfunction

    function automatic void model_entry(input int k, input int dim);
        int r, c, a;
        r = e_row[k];
        c = e_col[k];
        a = r * dim + c;
        if (r >= 0 && c >= 0 && r < dim && c < dim && a < DEPTH)
            model_mem[a] = acc_step(model_mem[a], e_prod[k]);
        else if (model_drop < 65535)
            model_drop++;
    endfunction

    task automatic load_ports(input int n, input int dim);
        for (int i = 0; i < MAXO; i++) begin
            products[i]          = 16'(e_prod[i]);
            row_coordinate[i]    = 16'(e_row[i]);
            column_coordinate[i] = 16'(e_col[i]);
        end
        batch_count = 9'(n);
        output_dim  = 9'(dim);
    endtask

    task automatic scramble_ports;
        for (int i = 0; i < MAXO; i++) begin
            products[i]          = 16'($urandom);
            row_coordinate[i]    = 16'($urandom);
            column_coordinate[i] = 16'($urandom);
        end
        batch_count = 9'($urandom);
        output_dim  = 9'($urandom);
    endtask

    // Handshake one batch, update the model, return cycles until ready again.
    task automatic do_batch(input int n, input int dim, output int cyc);
        int guard;
        load_ports(n, dim);
        guard = 0;
        while (!batch_ready && guard < 5000) begin @(posedge clk); #1; guard++; end
        batch_valid = 1'b1;
        @(posedge clk); #1;
        batch_valid = 1'b0;
        scramble_ports();
        for (int k = 0; k < n; k++) model_entry(k, dim);
        cyc = 0;
        while (!batch_ready && cyc < 5000) begin @(posedge clk); #1; cyc++; end
    endtask

    task automatic read_mem(input int a, output logic signed [W-1:0] v);
        rd_addr = AWT'(a);
        rd_en   = 1'b1;
        @(posedge clk); #1;
        rd_en   = 1'b0;
        v       = rd_data;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (batch_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", batch_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (dropped_count !== 16'd0) begin failures++; $display("FAIL reset_dropped got=%0d exp=0", dropped_count); end
        checks++; if (rd_data !== 16'sd0) begin failures++; $display("FAIL reset_rd_data got=%0d exp=0", rd_data); end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_clear;
        int cyc;
        logic signed [W-1:0] v;
        int bad;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        checks++; if (busy !== 1'b1 || batch_ready !== 1'b0) begin failures++; $display("FAIL clear_busy got busy=%b ready=%b exp busy=1 ready=0", busy, batch_ready); end
        cyc = 0;
        while (!batch_ready && cyc < 5000) begin @(posedge clk); #1; cyc++; end
        for (int a = 0; a < DEPTH; a++) model_mem[a] = 0;
        model_drop = 0;
        checks++; if (cyc !== DEPTH) begin failures++; $display("FAIL clear_cycles got=%0d exp=%0d", cyc, DEPTH); end
        checks++; if (dropped_count !== 16'd0) begin failures++; $display("FAIL clear_dropped got=%0d exp=0", dropped_count); end
        bad = 0;
        for (int a = 0; a < DEPTH; a++) begin
            read_mem(a, v);
            checks++;
            if (v !== 16'sd0) begin
                failures++;
                if (bad < 8) $display("FAIL clear_drain addr=%0d got=%0d exp=0", a, v);
                bad++;
            end
        end
    endtask

    task automatic test_basic;
        int cyc;
        logic signed [W-1:0] v;
        e_row[0] = 0; e_col[0] = 0; e_prod[0] = 5;
        e_row[1] = 1; e_col[1] = 2; e_prod[1] = 7;
        e_row[2] = 0; e_col[2] = 0; e_prod[2] = -2;
        do_batch(3, 4, cyc);
        checks++; if (cyc !== 4) begin failures++; $display("FAIL basic_ready_low got=%0d exp=4", cyc); end
        checks++; if (dropped_count !== 16'd0) begin failures++; $display("FAIL basic_dropped got=%0d exp=0", dropped_count); end
        read_mem(0, v);
        checks++; if (v !== 16'sd3) begin failures++; $display("FAIL basic_mem0 got=%0d exp=3", v); end
        read_mem(6, v);
        checks++; if (v !== 16'sd7) begin failures++; $display("FAIL basic_mem6 got=%0d exp=7", v); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rd_data !== 16'sd7) begin failures++; $display("FAIL drain_hold got=%0d exp=7", rd_data); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        logic signed [W-1:0] v;
        for (int k = 0; k < 4; k++) begin e_row[k] = 2; e_col[k] = 2; e_prod[k] = 100; end
        do_batch(4, 8, cyc);
        checks++; if (cyc !== 5) begin failures++; $display("FAIL b2b_ready_low got=%0d exp=5", cyc); end
        checks++; if (rd_data !== 16'sd7) begin failures++; $display("FAIL b2b_rd_hold got=%0d exp=7", rd_data); end
        read_mem(18, v);
        checks++; if (v !== 16'sd400) begin failures++; $display("FAIL b2b_mem18 got=%0d exp=400", v); end
    endtask

    task automatic test_out_of_range;
        int cyc;
        logic signed [W-1:0] v;
        e_row[0] = -1; e_col[0] = 0; e_prod[0] = int'($urandom_range(1, 1000));
        e_row[1] = 0;  e_col[1] = 4; e_prod[1] = int'($urandom_range(1, 1000));
        e_row[2] = 3;  e_col[2] = 3; e_prod[2] = int'($urandom_range(1, 1000));
        do_batch(3, 4, cyc);
        checks++; if (cyc !== 4) begin failures++; $display("FAIL oor_ready_low got=%0d exp=4", cyc); end
        checks++; if (dropped_count !== 16'd2) begin failures++; $display("FAIL oor_dropped got=%0d exp=2", dropped_count); end
        read_mem(15, v);
        checks++; if (v !== W'(model_mem[15])) begin failures++; $display("FAIL oor_mem15 got=%0d exp=%0d", v, model_mem[15]); end
        read_mem(0, v);
        checks++; if (v !== W'(model_mem[0])) begin failures++; $display("FAIL oor_mem0 got=%0d exp=%0d", v, model_mem[0]); end
    endtask

    task automatic test_count_zero;
        int cyc;
        logic signed [W-1:0] v;
        e_row[0] = 0; e_col[0] = 0; e_prod[0] = 999;
        do_batch(0, 4, cyc);
        checks++; if (cyc !== 0 || busy !== 1'b0) begin failures++; $display("FAIL zero_count_noop got cyc=%0d busy=%b exp cyc=0 busy=0", cyc, busy); end
        checks++; if (dropped_count !== 16'(model_drop)) begin failures++; $display("FAIL zero_count_dropped got=%0d exp=%0d", dropped_count, model_drop); end
        read_mem(0, v);
        checks++; if (v !== W'(model_mem[0])) begin failures++; $display("FAIL zero_count_mem0 got=%0d exp=%0d", v, model_mem[0]); end
    endtask

    task automatic test_random;
        int dims [8] = '{5, 1, 0, 33, 300, 12, 2, 64};
        int cyc, n, dim, bad;
        logic signed [W-1:0] v;
        foreach (dims[b]) begin
            dim = dims[b];
            n   = int'($urandom_range(1, MAXO));
            for (int k = 0; k < n; k++) begin
                e_row[k]  = int'($urandom_range(0, dim + 4)) - 2;
                e_col[k]  = int'($urandom_range(0, dim + 4)) - 2;
                e_prod[k] = int'($urandom_range(0, 65535)) - 32768;
            end
            do_batch(n, dim, cyc);
            checks++; if (cyc !== n + 1) begin failures++; $display("FAIL rand_ready_low batch=%0d got=%0d exp=%0d", b, cyc, n + 1); end
            checks++; if (dropped_count !== 16'(model_drop)) begin failures++; $display("FAIL rand_dropped batch=%0d got=%0d exp=%0d", b, dropped_count, model_drop); end
        end
        bad = 0;
        for (int a = 0; a < DEPTH; a++) begin
            read_mem(a, v);
            checks++;
            if (v !== W'(model_mem[a])) begin
                failures++;
                if (bad < 8) $display("FAIL rand_mem addr=%0d got=%0d exp=%0d", a, v, model_mem[a]);
                bad++;
            end
        end
    endtask

    task automatic test_clear_priority;
        int cyc, a;
        logic signed [W-1:0] v;
        e_row[0] = 0; e_col[0] = 0; e_prod[0] = 1234;
        load_ports(1, 1);
        batch_valid = 1'b1;
        clear       = 1'b1;
        @(posedge clk); #1;
        batch_valid = 1'b0;
        clear       = 1'b0;
        cyc = 0;
        while (!batch_ready && cyc < 5000) begin @(posedge clk); #1; cyc++; end
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 0;
        model_drop = 0;
        checks++; if (cyc !== DEPTH) begin failures++; $display("FAIL prio_clear_cycles got=%0d exp=%0d", cyc, DEPTH); end
        checks++; if (dropped_count !== 16'd0) begin failures++; $display("FAIL prio_dropped got=%0d exp=0", dropped_count); end
        read_mem(0, v);
        checks++; if (v !== 16'sd0) begin failures++; $display("FAIL prio_mem0 got=%0d exp=0", v); end
        for (int i = 0; i < 8; i++) begin
            a = int'($urandom_range(0, DEPTH - 1));
            read_mem(a, v);
            checks++; if (v !== 16'sd0) begin failures++; $display("FAIL prio_mem addr=%0d got=%0d exp=0", a, v); end
        end
    endtask

    task automatic test_saturation;
        int cyc;
        logic signed [W-1:0] v;
        for (int k = 0; k < 200; k++) begin e_row[k] = 0; e_col[k] = 0; e_prod[k] = 32767; end
        do_batch(200, 1, cyc);
        checks++; if (cyc !== 201) begin failures++; $display("FAIL sat_ready_low got=%0d exp=201", cyc); end
        read_mem(0, v);
        checks++; if (v !== W'(SAT_EXP)) begin failures++; $display("FAIL sat_mem0 got=%0d exp=%0d", v, SAT_EXP); end
    endtask

    task automatic test_reset_mid;
        logic signed [W-1:0] v;
        int guard;
        for (int k = 0; k < 10; k++) begin e_row[k] = 0; e_col[k] = k; e_prod[k] = k + 11; end
        load_ports(10, 16);
        guard = 0;
        while (!batch_ready && guard < 5000) begin @(posedge clk); #1; guard++; end
        batch_valid = 1'b1;
        @(posedge clk); #1;
        batch_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        // Entries 0 and 1 have completed their write edges before the abort.
        model_entry(0, 16);
        model_entry(1, 16);
        model_drop = 0;
        checks++; if (batch_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL abort_state got ready=%b busy=%b exp ready=1 busy=0", batch_ready, busy); end
        checks++; if (dropped_count !== 16'd0) begin failures++; $display("FAIL abort_dropped got=%0d exp=0", dropped_count); end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        for (int a = 0; a < 4; a++) begin
            read_mem(a, v);
            checks++; if (v !== W'(model_mem[a])) begin failures++; $display("FAIL abort_mem addr=%0d got=%0d exp=%0d", a, v, model_mem[a]); end
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_basic();
        test_back_to_back();
        test_out_of_range();
        test_count_zero();
        test_random();
        test_clear_priority();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
